// File: rtl/sync_bit_edge_filter.sv
// Glitch filter for a synchronized single bit in the clkB domain: qualified level,
// one-cycle rise/fall pulses and a saturating edge counter with sticky overflow.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// S_STABLE_LO  | level_o = 0, input agrees
// S_QUAL_HI    | level_o = 0, input has been 1 for r_qcnt consecutive samples
// S_STABLE_HI  | level_o = 1, input agrees
// S_QUAL_LO    | level_o = 1, input has been 0 for r_qcnt consecutive samples
module sync_bit_edge_filter #(
  parameter int   FILTER_CYCLES = 4,
  parameter int   CNT_WIDTH     = 16,
  parameter int   COUNT_EDGES   = 2,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic                 clkB,
  input  logic                 rstB_n,
  input  logic                 sync_bitB,
  input  logic                 count_clr,
  output logic                 level_o,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] edge_count,
  output logic                 cnt_ovf
);

  localparam int QW = $clog2(FILTER_CYCLES + 1);

  generate
    if (FILTER_CYCLES < 1) begin : g_bad_filter_cycles
      $error("sync_bit_edge_filter: FILTER_CYCLES must be >= 1");
    end
    if (COUNT_EDGES < 0 || COUNT_EDGES > 2) begin : g_bad_count_edges
      $error("sync_bit_edge_filter: COUNT_EDGES must be 0, 1 or 2");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
      $error("sync_bit_edge_filter: CNT_WIDTH must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_STABLE_LO = 2'd0,
    S_QUAL_HI   = 2'd1,
    S_STABLE_HI = 2'd2,
    S_QUAL_LO   = 2'd3
  } state_t;

  localparam state_t RESET_STATE = RESET_LEVEL ? S_STABLE_HI : S_STABLE_LO;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [QW-1:0]   r_qcnt;
  logic [QW-1:0]   w_qcnt_nxt;
  logic [QW-1:0]   w_qcnt_inc;
  logic            w_rise;
  logic            w_fall;
  logic            w_counted;
  logic            w_cnt_full;

  assign w_qcnt_inc = r_qcnt + 1'b1;

  always_ff @(posedge clkB or negedge rstB_n) begin
    if (!rstB_n) begin
      r_state <= RESET_STATE;
      r_qcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_qcnt  <= w_qcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_qcnt_nxt  = r_qcnt;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    case (r_state)
      S_STABLE_LO: begin
        if (sync_bitB) begin
          if (FILTER_CYCLES == 1) begin
            w_state_nxt = S_STABLE_HI;
            w_qcnt_nxt  = '0;
            w_rise      = 1'b1;
          end else begin
            w_state_nxt = S_QUAL_HI;
            w_qcnt_nxt  = QW'(1);
          end
        end
      end
      S_QUAL_HI: begin
        if (!sync_bitB) begin
          w_state_nxt = S_STABLE_LO;
          w_qcnt_nxt  = '0;
        end else if (w_qcnt_inc == QW'(FILTER_CYCLES)) begin
          w_state_nxt = S_STABLE_HI;
          w_qcnt_nxt  = '0;
          w_rise      = 1'b1;
        end else begin
          w_qcnt_nxt  = w_qcnt_inc;
        end
      end
      S_STABLE_HI: begin
        if (!sync_bitB) begin
          if (FILTER_CYCLES == 1) begin
            w_state_nxt = S_STABLE_LO;
            w_qcnt_nxt  = '0;
            w_fall      = 1'b1;
          end else begin
            w_state_nxt = S_QUAL_LO;
            w_qcnt_nxt  = QW'(1);
          end
        end
      end
      S_QUAL_LO: begin
        if (sync_bitB) begin
          w_state_nxt = S_STABLE_HI;
          w_qcnt_nxt  = '0;
        end else if (w_qcnt_inc == QW'(FILTER_CYCLES)) begin
          w_state_nxt = S_STABLE_LO;
          w_qcnt_nxt  = '0;
          w_fall      = 1'b1;
        end else begin
          w_qcnt_nxt  = w_qcnt_inc;
        end
      end
      default: begin
        w_state_nxt = RESET_STATE;
        w_qcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clkB or negedge rstB_n) begin
    if (!rstB_n) begin
      level_o    <= RESET_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      if (w_rise) begin
        level_o <= 1'b1;
      end else if (w_fall) begin
        level_o <= 1'b0;
      end
      rise_pulse <= w_rise;
      fall_pulse <= w_fall;
    end
  end

  assign w_counted  = (w_rise && (COUNT_EDGES != 1)) || (w_fall && (COUNT_EDGES != 0));
  assign w_cnt_full = &edge_count;

  // A clear that coincides with a counted edge still records that edge.
  always_ff @(posedge clkB or negedge rstB_n) begin
    if (!rstB_n) begin
      edge_count <= '0;
      cnt_ovf    <= 1'b0;
    end else if (count_clr) begin
      edge_count <= w_counted ? CNT_WIDTH'(1) : '0;
      cnt_ovf    <= 1'b0;
    end else if (w_counted) begin
      if (w_cnt_full) begin
        cnt_ovf <= 1'b1;
      end else begin
        edge_count <= edge_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_bit_edge_filter.sv
// Directed bench for sync_bit_edge_filter: per-cycle vector table on the default
// configuration, plus hand sequences for counter saturation and mid-qualification reset.
module tb_sync_bit_edge_filter;

  logic        clkB;
  logic        rstB_n;
  logic        sync_bitB;
  logic        count_clr;

  logic        level_o,    level_w2;
  logic        rise_pulse, rise_w2;
  logic        fall_pulse, fall_w2;
  logic [15:0] edge_count;
  logic [1:0]  count_w2;
  logic        cnt_ovf,    ovf_w2;

  sync_bit_edge_filter #(
    .FILTER_CYCLES(4), .CNT_WIDTH(16), .COUNT_EDGES(2), .RESET_LEVEL(1'b0)
  ) dut (
    .clkB(clkB), .rstB_n(rstB_n), .sync_bitB(sync_bitB), .count_clr(count_clr),
    .level_o(level_o), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .edge_count(edge_count), .cnt_ovf(cnt_ovf)
  );

  sync_bit_edge_filter #(
    .FILTER_CYCLES(4), .CNT_WIDTH(2), .COUNT_EDGES(2), .RESET_LEVEL(1'b0)
  ) dut_w2 (
    .clkB(clkB), .rstB_n(rstB_n), .sync_bitB(sync_bitB), .count_clr(count_clr),
    .level_o(level_w2), .rise_pulse(rise_w2), .fall_pulse(fall_w2),
    .edge_count(count_w2), .cnt_ovf(ovf_w2)
  );

  initial clkB = 1'b0;
  always #5 clkB = ~clkB;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic s;
    logic clr;
    logic lvl;
    logic rise;
    logic fall;
    int   cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic clr);
    sync_bitB = s;
    count_clr = clr;
    @(posedge clkB);
    #1;
  endtask

  task automatic add(input logic s, input logic clr, input logic l, input logic r,
                     input logic f, input int c);
    vec_t v;
    v.s = s; v.clr = clr; v.lvl = l; v.rise = r; v.fall = f; v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"}, int'(level_o), 0);
    chk({tag, "_rise"},  int'(rise_pulse), 0);
    chk({tag, "_fall"},  int'(fall_pulse), 0);
    chk({tag, "_cnt"},   int'(edge_count), 0);
    chk({tag, "_ovf"},   int'(cnt_ovf), 0);
    chk({tag, "_w2cnt"}, int'(count_w2), 0);
    chk({tag, "_w2ovf"}, int'(ovf_w2), 0);
  endtask

  // Holds the input at val for four samples and checks the flip lands on the fourth.
  task automatic qual_edge(input logic val, input string tag);
    for (int i = 0; i < 3; i++) begin
      step(val, 1'b0);
      chk({tag, "_hold_level"}, int'(level_o), int'(!val));
    end
    step(val, 1'b0);
    chk({tag, "_level"}, int'(level_o), int'(val));
    chk({tag, "_rise"},  int'(rise_pulse), int'(val));
    chk({tag, "_fall"},  int'(fall_pulse), int'(!val));
  endtask

  initial begin
    rstB_n    = 1'b0;
    sync_bitB = 1'b0;
    count_clr = 1'b0;
    #12;
    chk_reset_vals("in_reset");
    @(negedge clkB);
    rstB_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      chk($sformatf("idle%0d_level", i), int'(level_o), 0);
      chk($sformatf("idle%0d_pulse", i), int'(rise_pulse | fall_pulse), 0);
      chk($sformatf("idle%0d_cnt", i), int'(edge_count), 0);
    end

    // rise after 4 highs, fall after 4 lows
    add(1,0, 0,0,0, 0); add(1,0, 0,0,0, 0); add(1,0, 0,0,0, 0); add(1,0, 1,1,0, 1);
    add(1,0, 1,0,0, 1);
    add(0,0, 1,0,0, 1); add(0,0, 1,0,0, 1); add(0,0, 1,0,0, 1); add(0,0, 0,0,1, 2);
    add(0,0, 0,0,0, 2);
    // 3-cycle glitch rejected, then a 4-cycle high flips
    add(1,0, 0,0,0, 2); add(1,0, 0,0,0, 2); add(1,0, 0,0,0, 2); add(0,0, 0,0,0, 2);
    add(1,0, 0,0,0, 2); add(1,0, 0,0,0, 2); add(1,0, 0,0,0, 2); add(1,0, 1,1,0, 3);
    add(1,0, 1,0,0, 3);
    // low glitch while high
    add(0,0, 1,0,0, 3); add(1,0, 1,0,0, 3); add(1,0, 1,0,0, 3);
    // clear coincident with a qualified fall keeps that edge
    add(0,0, 1,0,0, 3); add(0,0, 1,0,0, 3); add(0,0, 1,0,0, 3); add(0,1, 0,0,1, 1);
    add(0,0, 0,0,0, 1);
    add(0,1, 0,0,0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].clr);
      chk($sformatf("v%0d_level", i), int'(level_o), int'(tbl[i].lvl));
      chk($sformatf("v%0d_rise", i),  int'(rise_pulse), int'(tbl[i].rise));
      chk($sformatf("v%0d_fall", i),  int'(fall_pulse), int'(tbl[i].fall));
      chk($sformatf("v%0d_cnt", i),   int'(edge_count), tbl[i].cnt);
      chk($sformatf("v%0d_ovf", i),   int'(cnt_ovf), 0);
      chk($sformatf("v%0d_w2cnt", i), int'(count_w2), tbl[i].cnt);
    end

    // saturation on the 2-bit counter: 1,2,3,3,3 with overflow from the 4th edge
    for (int e = 1; e <= 5; e++) begin
      qual_edge((e % 2) == 1, $sformatf("sat%0d", e));
      chk($sformatf("sat%0d_cnt16", e), int'(edge_count), e);
      chk($sformatf("sat%0d_ovf16", e), int'(cnt_ovf), 0);
      chk($sformatf("sat%0d_cnt2", e), int'(count_w2), (e >= 3) ? 3 : e);
      chk($sformatf("sat%0d_ovf2", e), int'(ovf_w2), (e >= 4) ? 1 : 0);
    end
    qual_edge(1'b0, "sat6");
    chk("sat6_cnt2", int'(count_w2), 3);
    chk("sat6_ovf2", int'(ovf_w2), 1);

    // reset asserted mid-qualification (counter = 2)
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("prerst_level", int'(level_o), 0);
    #3;
    rstB_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    step(1'b1, 1'b0);
    chk_reset_vals("held_rst");
    @(negedge clkB);
    rstB_n = 1'b1;
    qual_edge(1'b1, "post_rst");
    chk("post_rst_cnt", int'(edge_count), 1);
    step(1'b1, 1'b0);
    chk("post_rst_rise_clear", int'(rise_pulse), 0);
    chk("post_rst_level_hold", int'(level_o), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  always @(negedge clkB) begin
    if (rise_pulse && fall_pulse) begin
      n_tests++;
      n_fail++;
      $display("FAIL both_pulses: rise=%0d fall=%0d expected not both high", rise_pulse, fall_pulse);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time %0t exceeded limit", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
